// File: rtl/parking_space_counter.sv
// Parking lot free-space tracker with entry-gate arbitration.
// Exits credit the count through an adder path; entries debit it through a ripple borrow chain.

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module psc_borrow_chk (
    input logic clk,
    input logic rst_n,
    input logic borrow_out
);
    // An accepted entry always sees a non-zero effective count, so the chain never borrows out.
    borrow_never: assert property (@(posedge clk) disable iff (!rst_n) (borrow_out == 1'b0));
endmodule

module parking_space_counter #(
    parameter int CAPACITY    = 8,
    parameter int WIDTH       = 4,
    parameter int GATE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             entry_req,
    input  logic             exit_event,
    output logic             entry_grant,
    output logic             entry_deny,
    output logic             gate_open,
    output logic [WIDTH-1:0] free_spaces,
    output logic             lot_full,
    output logic             lot_empty,
    output logic             overflow_err
);
    localparam int CW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [WIDTH-1:0] CAP_W    = WIDTH'(CAPACITY);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [CW-1:0]    ZERO_C   = {CW{1'b0}};
    localparam logic [CW-1:0]    ONE_C    = CW'(1);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_CLOSE = 2'd2
    } state_t;

    state_t           state_r, state_next_s;
    logic [CW-1:0]    cnt_r, cnt_next_s;
    logic             pend_r, pend_next_s;
    logic             entry_q_r, exit_q_r;
    logic [WIDTH-1:0] free_r, free_next_s;
    logic             full_r, empty_r, grant_r, deny_r, gate_r, ovf_r;
    logic             full_next_s, empty_next_s, gate_next_s;
    logic             entry_ev_s, exit_ev_s, credit_s, ovf_hit_s, eff_nonzero_s;
    logic             accept_s, deny_s;
    logic [WIDTH-1:0] inc_val_s, sub_b_s, dec_val_s;
    logic [WIDTH:0]   borrow_s;

    assign entry_ev_s    = entry_req & ~entry_q_r;
    assign exit_ev_s     = exit_event & ~exit_q_r;
    assign credit_s      = exit_ev_s & (free_r != CAP_W);
    assign ovf_hit_s     = exit_ev_s & (free_r == CAP_W);
    // Exit credit is applied first, so an entry in the same cycle can use the freed space.
    assign inc_val_s     = free_r + WIDTH'(credit_s);
    assign eff_nonzero_s = (inc_val_s != ZERO_W);
    assign sub_b_s       = WIDTH'(accept_s);
    assign borrow_s[0]   = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_sub
            full_subtractor u_fs (
                .a    (inc_val_s[gi]),
                .b    (sub_b_s[gi]),
                .bin  (borrow_s[gi]),
                .d    (dec_val_s[gi]),
                .bout (borrow_s[gi+1])
            );
        end
    endgenerate

    psc_borrow_chk u_chk (
        .clk        (clk),
        .rst_n      (reset_n),
        .borrow_out (borrow_s[WIDTH])
    );

    // State register plus all registered outputs; reset drops the gate and loses any pending request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= ZERO_C;
            pend_r    <= 1'b0;
            entry_q_r <= 1'b0;
            exit_q_r  <= 1'b0;
            free_r    <= CAP_W;
            full_r    <= 1'b0;
            empty_r   <= 1'b1;
            grant_r   <= 1'b0;
            deny_r    <= 1'b0;
            gate_r    <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            pend_r    <= pend_next_s;
            entry_q_r <= entry_req;
            exit_q_r  <= exit_event;
            free_r    <= free_next_s;
            full_r    <= full_next_s;
            empty_r   <= empty_next_s;
            grant_r   <= accept_s;
            deny_r    <= deny_s;
            gate_r    <= gate_next_s;
            ovf_r     <= ovf_r | ovf_hit_s;
        end
    end

    // Next-state, gate countdown and request arbitration; a pending request is replayed on the first IDLE cycle.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        pend_next_s  = pend_r;
        accept_s     = 1'b0;
        deny_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pend_r || entry_ev_s) begin
                    pend_next_s = 1'b0;
                    if (eff_nonzero_s) begin
                        accept_s     = 1'b1;
                        state_next_s = ST_OPEN;
                        cnt_next_s   = CNT_LOAD;
                    end else begin
                        deny_s = 1'b1;
                    end
                end else begin
                    pend_next_s = 1'b0;
                end
            end
            ST_OPEN, ST_CLOSE: begin
                if (state_r == ST_CLOSE) begin
                    state_next_s = ST_IDLE;
                end else if (cnt_r == ZERO_C) begin
                    state_next_s = ST_CLOSE;
                end else begin
                    cnt_next_s = cnt_r - ONE_C;
                end
                if (entry_ev_s && !pend_r) begin
                    if (eff_nonzero_s) begin
                        pend_next_s = 1'b1;
                    end else begin
                        deny_s = 1'b1;
                    end
                end else begin
                    pend_next_s = pend_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                pend_next_s  = 1'b0;
            end
        endcase
    end

    // Output decode for the next cycle; the chain result already includes both credit and debit.
    always_comb begin
        free_next_s  = dec_val_s;
        full_next_s  = (dec_val_s == ZERO_W);
        empty_next_s = (dec_val_s == CAP_W);
        gate_next_s  = (state_next_s == ST_OPEN);
    end

    assign entry_grant  = grant_r;
    assign entry_deny   = deny_r;
    assign gate_open    = gate_r;
    assign free_spaces  = free_r;
    assign lot_full     = full_r;
    assign lot_empty    = empty_r;
    assign overflow_err = ovf_r;
endmodule

// File: tb/tb_parking_space_counter.sv
// Directed self-checking bench for parking_space_counter (CAPACITY=8, WIDTH=4, GATE_CYCLES=4).
// Inputs change just after a falling edge; outputs are sampled on falling edges.

module tb_parking_space_counter;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       entry_req;
    logic       exit_event;
    logic       entry_grant;
    logic       entry_deny;
    logic       gate_open;
    logic [3:0] free_spaces;
    logic       lot_full;
    logic       lot_empty;
    logic       overflow_err;

    int checks   = 0;
    int failures = 0;

    parking_space_counter #(.CAPACITY(8), .WIDTH(4), .GATE_CYCLES(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .entry_req    (entry_req),
        .exit_event   (exit_event),
        .entry_grant  (entry_grant),
        .entry_deny   (entry_deny),
        .gate_open    (gate_open),
        .free_spaces  (free_spaces),
        .lot_full     (lot_full),
        .lot_empty    (lot_empty),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_exit();
        exit_event = 1'b1;
        @(negedge clk);
        exit_event = 1'b0;
        @(negedge clk);
    endtask

    // One entry edge, check the response, then let the gate cycle run back to IDLE.
    task automatic entry_and_wait(input logic exp_grant, input logic [3:0] exp_free);
        entry_req = 1'b1;
        @(negedge clk);
        check("fill_grant", entry_grant, exp_grant);
        check("fill_free", free_spaces, exp_free);
        entry_req = 1'b0;
        cyc(6);
    endtask

    initial begin
        int hi;
        int grants;
        int denies;
        reset_n    = 1'b0;
        entry_req  = 1'b0;
        exit_event = 1'b0;
        cyc(3);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_free", free_spaces, 32'd8);
        check("rst_empty", lot_empty, 32'd1);
        check("rst_full", lot_full, 32'd0);
        check("rst_grant", entry_grant, 32'd0);
        check("rst_deny", entry_deny, 32'd0);
        check("rst_gate", gate_open, 32'd0);
        check("rst_ovf", overflow_err, 32'd0);

        // First entry: grant, count 8->7, gate high for exactly 4 cycles.
        entry_req = 1'b1;
        @(negedge clk);
        check("e1_grant", entry_grant, 32'd1);
        check("e1_free", free_spaces, 32'd7);
        check("e1_gate", gate_open, 32'd1);
        check("e1_empty", lot_empty, 32'd0);
        entry_req = 1'b0;
        hi = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            hi += int'(gate_open);
            if (i == 0) check("e1_grant_pulse", entry_grant, 32'd0);
        end
        check("e1_gate_cycles", hi, 32'd4);

        // Fill the lot, then a refused ninth entry.
        for (int k = 6; k >= 0; k--) entry_and_wait(1'b1, 4'(k));
        check("full_flag", lot_full, 32'd1);
        entry_req = 1'b1;
        @(negedge clk);
        check("deny_pulse", entry_deny, 32'd1);
        check("deny_grant", entry_grant, 32'd0);
        check("deny_gate", gate_open, 32'd0);
        check("deny_free", free_spaces, 32'd0);
        entry_req = 1'b0;
        @(negedge clk);
        check("deny_one_cycle", entry_deny, 32'd0);

        // Full lot, simultaneous entry and exit: exit credited first.
        entry_req  = 1'b1;
        exit_event = 1'b1;
        @(negedge clk);
        check("sim_grant", entry_grant, 32'd1);
        check("sim_free", free_spaces, 32'd0);
        check("sim_gate", gate_open, 32'd1);
        check("sim_full", lot_full, 32'd1);
        entry_req  = 1'b0;
        exit_event = 1'b0;
        cyc(6);

        // Pending request during the gate cycle; a third edge is dropped.
        repeat (3) pulse_exit();
        check("exit3_free", free_spaces, 32'd3);
        check("exit3_full", lot_full, 32'd0);
        entry_req = 1'b1;
        @(negedge clk);
        check("pend_first_grant", entry_grant, 32'd1);
        check("pend_first_free", free_spaces, 32'd2);
        entry_req = 1'b0;
        @(negedge clk);
        entry_req = 1'b1;
        @(negedge clk);
        check("pend_no_grant", entry_grant, 32'd0);
        check("pend_no_deny", entry_deny, 32'd0);
        check("pend_free_hold", free_spaces, 32'd2);
        entry_req = 1'b0;
        @(negedge clk);
        entry_req = 1'b1;
        @(negedge clk);
        check("third_no_grant", entry_grant, 32'd0);
        check("third_no_deny", entry_deny, 32'd0);
        entry_req = 1'b0;
        @(negedge clk);
        check("close_idle_gate", gate_open, 32'd0);
        check("close_idle_grant", entry_grant, 32'd0);
        @(negedge clk);
        check("pend_grant", entry_grant, 32'd1);
        check("pend_free", free_spaces, 32'd1);
        check("pend_gate", gate_open, 32'd1);
        cyc(8);
        check("third_dropped_free", free_spaces, 32'd1);
        check("third_dropped_gate", gate_open, 32'd0);

        // Back to empty, then an exit on an empty lot sets the sticky overflow flag.
        repeat (7) pulse_exit();
        check("empty_free", free_spaces, 32'd8);
        check("empty_flag", lot_empty, 32'd1);
        check("empty_ovf", overflow_err, 32'd0);
        pulse_exit();
        check("ovf_set", overflow_err, 32'd1);
        check("ovf_free", free_spaces, 32'd8);
        cyc(10);
        check("ovf_sticky", overflow_err, 32'd1);
        reset_n = 1'b0;
        #1;
        check("ovf_reset", overflow_err, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Held request counts once.
        grants = 0;
        denies = 0;
        entry_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            grants += int'(entry_grant);
            denies += int'(entry_deny);
        end
        check("hold_grants", grants, 32'd1);
        check("hold_denies", denies, 32'd0);
        check("hold_free", free_spaces, 32'd7);
        entry_req = 1'b0;
        cyc(2);

        // Reset mid-gate with a pending request: everything back to reset values at once.
        entry_req = 1'b1;
        @(negedge clk);
        check("mid_gate_open", gate_open, 32'd1);
        check("mid_free", free_spaces, 32'd6);
        entry_req = 1'b0;
        @(negedge clk);
        entry_req = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("arst_gate", gate_open, 32'd0);
        check("arst_free", free_spaces, 32'd8);
        check("arst_empty", lot_empty, 32'd1);
        check("arst_full", lot_full, 32'd0);
        check("arst_grant", entry_grant, 32'd0);
        entry_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        hi = 0;
        grants = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            hi += int'(gate_open);
            grants += int'(entry_grant);
        end
        check("pend_lost_gate", hi, 32'd0);
        check("pend_lost_grant", grants, 32'd0);
        check("pend_lost_free", free_spaces, 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/parking_space_counter.md
Name: parking_space_counter

Overview:
- Tracks free parking spaces for one lot and arbitrates the entry gate.
- Consumes the rising edges of the entry-request and exit-sensor lines.
- Decrements the free count through a ripple borrow chain of full_subtractor cells and increments it through an adder path.
- Drives the gate timing, the lot status flags and the free-space value that feeds the display stage downstream.

Parameters:
- CAPACITY, 8, total spaces in the lot; reset value of the free count.
- WIDTH, 4, width of the free-space count; must satisfy 2^WIDTH > CAPACITY.
- GATE_CYCLES, 4, number of cycles gate_open stays high per granted entry; must be ≥ 1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- entry_req  input  1  level from the entry button; only its rising edge is a request.
- exit_event  input  1  level from the exit sensor; only its rising edge is a departure.
- entry_grant  output  1  one-cycle pulse when an entry is accepted.
- entry_deny  output  1  one-cycle pulse when an entry is refused because the lot is full.
- gate_open  output  1  entry gate drive.
- free_spaces  output  WIDTH  current free-space count.
- lot_full  output  1  high when free_spaces == 0.
- lot_empty  output  1  high when free_spaces == CAPACITY.
- overflow_err  output  1  sticky flag: an exit was seen while the lot was already empty.

Behaviour:
- Reset (reset_n low, asynchronous) sets:
  - free_spaces = CAPACITY, lot_empty = 1, lot_full = 0.
  - entry_grant = entry_deny = gate_open = overflow_err = 0.
  - FSM = IDLE, pending flag = 0, edge-detect registers = 0.
- Reset asserted mid-gate-cycle aborts the cycle immediately: gate_open drops asynchronously and any pending request is lost.
- Edge detection: entry_req and exit_event are registered once. An event is input==1 while the previous registered value==0. Holding an input high counts as exactly one event.
- Free count arithmetic:
  - Exit event with free_spaces < CAPACITY: +1.
  - Exit event with free_spaces == CAPACITY: count held, overflow_err set to 1 and held until reset.
  - Accepted entry: −1 through the borrow chain. The borrow-out of the chain must never assert; a borrow-out of 1 is a design error and is checked by an assertion.
- Entry acceptance:
  - Effective free = free_spaces + (exit event this cycle ? 1 : 0), capped at CAPACITY. An exit in the same cycle is credited first.
  - A request is accepted when effective free > 0 and FSM == IDLE.
  - Accept and exit in the same cycle leave free_spaces unchanged.
  - A request arriving with effective free == 0 produces an entry_deny pulse on the next cycle. It is not queued.
- Latency: an event edge sampled at clock edge N produces the response at edge N+1, all registered together:
  - entry_grant or entry_deny pulse,
  - free_spaces update,
  - lot_full / lot_empty update,
  - gate_open rise.
- Gate FSM:
  - IDLE: gate_open = 0. An accepted request moves to OPEN, loads the gate counter with GATE_CYCLES − 1, and asserts gate_open.
  - OPEN: gate_open = 1. The counter decrements each cycle; at 0 the FSM moves to CLOSE.
  - CLOSE: gate_open = 0 for exactly one cycle, then IDLE.
- Pending request:
  - A request in OPEN or CLOSE with effective free > 0 sets a one-deep pending flag; no grant is issued yet.
  - The pending request is re-evaluated on the first IDLE cycle against the current free count, as if it were a new request: grant if free > 0, otherwise deny.
  - Further requests while pending == 1 are dropped silently.
- Flag timing: lot_full and lot_empty are pure functions of the registered free_spaces.
- Exits are always processed in every FSM state.

Test Plan:
- Reset, then one entry_req edge → entry_grant pulse 1 cycle later; free_spaces 8→7; gate_open high for exactly 4 cycles, then low; lot_empty falls from 1 to 0.
- 8 spaced entries → free_spaces reaches 0 and lot_full = 1; 9th entry → entry_deny pulse, no gate_open, free_spaces stays 0.
- Lot full, entry_req and exit_event edges in the same cycle → entry_grant pulse; free_spaces stays 0; gate opens.
- Second entry edge 2 cycles after a grant (gate OPEN) → no immediate response; grant issued on the first IDLE cycle after CLOSE; free_spaces decrements once more; a third edge during the same window is dropped.
- exit_event edge at free_spaces = 8 → overflow_err = 1, free_spaces stays 8; flag remains 1 through 10 further cycles until reset_n is pulsed low.
- entry_req held high for 20 cycles → exactly one grant; reset_n asserted while gate_open = 1 → gate_open, pending and all flags return to reset values immediately; free_spaces returns to 8.
